// File: rtl/sat_chan_sched_if.sv
// Host-side configuration and commit handshake for sat_chan_sched.
interface sat_chan_sched_if #(
  parameter int NUM_CHAN = 12
);
  localparam int CW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_chan;
  logic [1:0]    cfg_field;
  logic [31:0]   cfg_data;
  logic          cfg_err;
  logic          commit_req;
  logic          epoch;
  logic          commit_pending;
  logic          commit_done;

  modport master (
    output cfg_valid, cfg_chan, cfg_field, cfg_data, commit_req, epoch,
    input  cfg_ready, cfg_err, commit_pending, commit_done
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_field, cfg_data, commit_req, epoch,
    output cfg_ready, cfg_err, commit_pending, commit_done
  );
endinterface

// File: rtl/sat_chan_sched.sv
// Shadow/active channel configuration bank committed atomically on a C/A epoch.
// Define SAT_CHAN_SCHED_GAIN_RAMP_EN to slew gain toward its target by RAMP_STEP per clock.
module sat_chan_sched #(
  parameter int          NUM_CHAN  = 12,
  parameter logic [15:0] RAMP_STEP = 16'd256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sat_chan_sched_if.slave         bus,
  output logic [NUM_CHAN-1:0]     chan_enable,
  output logic [32*NUM_CHAN-1:0]  chan_freq,
  output logic [16*NUM_CHAN-1:0]  chan_gain,
  output logic [6*NUM_CHAN-1:0]   chan_ca_sel
);
  localparam int CW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, APPLY} state_e;

  state_e state_q, state_d;

  logic [NUM_CHAN-1:0]    sh_en_q,   act_en_q;
  logic [32*NUM_CHAN-1:0] sh_freq_q, act_freq_q;
  logic [16*NUM_CHAN-1:0] sh_gain_q, gain_q;
  logic [6*NUM_CHAN-1:0]  sh_ca_q,   act_ca_q;
  logic                   err_q, pending_q, done_q;
  logic                   wr_accept, in_range;

  assign in_range  = ({1'b0, bus.cfg_chan} < (CW+1)'(NUM_CHAN));
  assign wr_accept = bus.cfg_valid && bus.cfg_ready;

  // cfg_ready is the only combinational output; it is held low during reset.
  always_comb begin
    state_d       = state_q;
    bus.cfg_ready = rst_n && (state_q == IDLE);
    unique case (state_q)
      IDLE:    if (bus.commit_req) state_d = ARMED;
      ARMED:   if (bus.epoch)      state_d = APPLY;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      err_q      <= 1'b0;
      pending_q  <= 1'b0;
      done_q     <= 1'b0;
      sh_en_q    <= '0;
      sh_freq_q  <= '0;
      sh_gain_q  <= '0;
      sh_ca_q    <= '0;
      act_en_q   <= '0;
      act_freq_q <= '0;
      act_ca_q   <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= wr_accept && !in_range;
      pending_q <= (state_d != IDLE);
      done_q    <= (state_q == APPLY);
      for (int i = 0; i < NUM_CHAN; i++) begin
        if (wr_accept && in_range && (bus.cfg_chan == CW'(i))) begin
          unique case (bus.cfg_field)
            2'd0: sh_freq_q[32*i +: 32] <= bus.cfg_data;
            2'd1: sh_gain_q[16*i +: 16] <= bus.cfg_data[15:0];
            2'd2: sh_ca_q[6*i +: 6]     <= bus.cfg_data[5:0];
            2'd3: sh_en_q[i]            <= bus.cfg_data[0];
            default: ;
          endcase
        end
      end
      if (state_q == APPLY) begin
        act_en_q   <= sh_en_q;
        act_freq_q <= sh_freq_q;
        act_ca_q   <= sh_ca_q;
      end
    end
  end

`ifdef SAT_CHAN_SCHED_GAIN_RAMP_EN
  logic [16*NUM_CHAN-1:0] tgt_q, gain_d;

  function automatic logic [15:0] slew(input logic [15:0] cur, input logic [15:0] tgt);
    logic [16:0] diff;
    if (cur < tgt) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      slew = (diff <= {1'b0, RAMP_STEP}) ? tgt : cur + RAMP_STEP;
    end else begin
      diff = {1'b0, cur} - {1'b0, tgt};
      slew = (diff <= {1'b0, RAMP_STEP}) ? tgt : cur - RAMP_STEP;
    end
  endfunction

  // During APPLY the new target is taken straight from shadow so the first step lands with commit_done.
  always_comb begin
    gain_d = gain_q;
    for (int i = 0; i < NUM_CHAN; i++) begin
      gain_d[16*i +: 16] = slew(gain_q[16*i +: 16],
                                (state_q == APPLY) ? sh_gain_q[16*i +: 16] : tgt_q[16*i +: 16]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tgt_q  <= '0;
      gain_q <= '0;
    end else begin
      gain_q <= gain_d;
      if (state_q == APPLY) tgt_q <= sh_gain_q;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gain_q <= '0;
    end else if (state_q == APPLY) begin
      gain_q <= sh_gain_q;
    end
  end
`endif

  assign bus.cfg_err        = err_q;
  assign bus.commit_pending = pending_q;
  assign bus.commit_done    = done_q;
  assign chan_enable        = act_en_q;
  assign chan_freq          = act_freq_q;
  assign chan_gain          = gain_q;
  assign chan_ca_sel        = act_ca_q;
endmodule

// File: tb/tb_sat_chan_sched.sv
// Directed-vector bench for sat_chan_sched with NUM_CHAN = 12 (ramp vectors under SAT_CHAN_SCHED_GAIN_RAMP_EN).
module tb_sat_chan_sched;
  localparam int NC = 12;

  logic clk = 1'b0;
  logic rst_n;
  logic [NC-1:0]    chan_enable;
  logic [32*NC-1:0] chan_freq;
  logic [16*NC-1:0] chan_gain;
  logic [6*NC-1:0]  chan_ca_sel;

  int vectorCount = 0;
  int errCount    = 0;

  logic [32*NC-1:0] expFreq;

  sat_chan_sched_if #(.NUM_CHAN(NC)) bus ();

  sat_chan_sched #(.NUM_CHAN(NC), .RAMP_STEP(16'd256)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .chan_enable (chan_enable),
    .chan_freq   (chan_freq),
    .chan_gain   (chan_gain),
    .chan_ca_sel (chan_ca_sel)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [383:0] actual, input logic [383:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int ch, input int fld, input logic [31:0] data);
    bus.cfg_valid = 1'b1;
    bus.cfg_chan  = 4'(ch);
    bus.cfg_field = 2'(fld);
    bus.cfg_data  = data;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  // Arm, strobe epoch right away, then stop in the commit_done cycle.
  task automatic doCommit(input string tag);
    bus.commit_req = 1'b1;
    tick();
    bus.commit_req = 1'b0;
    bus.epoch = 1'b1;
    tick();
    bus.epoch = 1'b0;
    tick();
    checkOutput(tag, 384'(bus.commit_done), 384'(1));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_chan = '0; bus.cfg_field = '0; bus.cfg_data = '0;
    bus.commit_req = 1'b0; bus.epoch = 1'b0;
    repeat (3) tick();
    checkOutput("rstReady",   384'(bus.cfg_ready),      384'(0));
    checkOutput("rstEnable",  384'(chan_enable),        384'(0));
    checkOutput("rstFreq",    384'(chan_freq),          384'(0));
    checkOutput("rstPending", 384'(bus.commit_pending), 384'(0));
    checkOutput("rstDone",    384'(bus.commit_done),    384'(0));
    rst_n = 1'b1;
    #1;
    checkOutput("readyAfterRst", 384'(bus.cfg_ready), 384'(1));

    applyStimulus(3, 0, 32'h0123_4567);
    applyStimulus(3, 1, 32'h0000_8000);
    applyStimulus(3, 2, 32'd17);
    applyStimulus(3, 3, 32'd1);
    checkOutput("errInRange", 384'(bus.cfg_err), 384'(0));
    bus.commit_req = 1'b1;
    tick();
    bus.commit_req = 1'b0;
    checkOutput("armPending", 384'(bus.commit_pending), 384'(1));
    checkOutput("armReady",   384'(bus.cfg_ready),      384'(0));
    repeat (9) tick();
    bus.epoch = 1'b1;
    tick();
    bus.epoch = 1'b0;
    checkOutput("applyDone",  384'(bus.commit_done),       384'(0));
    checkOutput("applyFreq3", 384'(chan_freq[32*3 +: 32]), 384'(0));
    tick();
    checkOutput("c1Done",    384'(bus.commit_done),       384'(1));
    checkOutput("c1Pending", 384'(bus.commit_pending),    384'(0));
    checkOutput("c1Freq",    384'(chan_freq),             384'(32'h0123_4567) << 96);
    checkOutput("c1Ca3",     384'(chan_ca_sel[6*3 +: 6]), 384'(17));
    checkOutput("c1CaAll",   384'(chan_ca_sel),           384'(6'd17) << 18);
    checkOutput("c1Enable",  384'(chan_enable),           384'(12'h008));
`ifdef SAT_CHAN_SCHED_GAIN_RAMP_EN
    checkOutput("c1Gain3",   384'(chan_gain[16*3 +: 16]), 384'(16'h0100));
`else
    checkOutput("c1Gain3",   384'(chan_gain[16*3 +: 16]), 384'(16'h8000));
`endif
    tick();
    checkOutput("c1DoneEnd", 384'(bus.commit_done), 384'(0));
    checkOutput("c1Ready",   384'(bus.cfg_ready),   384'(1));

    // Epoch in IDLE with an uncommitted shadow write must change nothing.
    applyStimulus(3, 0, 32'hAAAA_0000);
    bus.epoch = 1'b1;
    tick();
    bus.epoch = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput("idleEpochDone", 384'(bus.commit_done), 384'(0));
      tick();
    end
    checkOutput("idleEpochFreq", 384'(chan_freq[32*3 +: 32]), 384'(32'h0123_4567));

    // commit_req with epoch in the same cycle waits for the next epoch.
    bus.commit_req = 1'b1; bus.epoch = 1'b1;
    tick();
    bus.commit_req = 1'b0; bus.epoch = 1'b0;
    checkOutput("sameCyclePending", 384'(bus.commit_pending), 384'(1));
    repeat (3) tick();
    checkOutput("sameCycleDone", 384'(bus.commit_done),       384'(0));
    checkOutput("sameCycleFreq", 384'(chan_freq[32*3 +: 32]), 384'(32'h0123_4567));
    bus.epoch = 1'b1;
    tick();
    bus.epoch = 1'b0;
    tick();
    checkOutput("sameCycleDone2", 384'(bus.commit_done),       384'(1));
    checkOutput("sameCycleFreq2", 384'(chan_freq[32*3 +: 32]), 384'(32'hAAAA_0000));

    // cfg_valid held through ARMED is not accepted until IDLE.
    bus.commit_req = 1'b1;
    tick();
    bus.commit_req = 1'b0;
    bus.cfg_valid = 1'b1; bus.cfg_chan = 4'd5; bus.cfg_field = 2'd0; bus.cfg_data = 32'h0000_5555;
    tick();
    checkOutput("heldReady", 384'(bus.cfg_ready), 384'(0));
    tick();
    bus.epoch = 1'b1;
    tick();
    bus.epoch = 1'b0;
    tick();
    checkOutput("heldDone",  384'(bus.commit_done),       384'(1));
    checkOutput("heldFreq5", 384'(chan_freq[32*5 +: 32]), 384'(0));
    tick();
    bus.cfg_valid = 1'b0;
    doCommit("heldCommit");
    checkOutput("heldFreq5b", 384'(chan_freq[32*5 +: 32]), 384'(32'h0000_5555));

    // Out-of-range channels pulse cfg_err and are dropped.
    applyStimulus(13, 0, 32'hDEAD_BEEF);
    checkOutput("err13",     384'(bus.cfg_err), 384'(1));
    tick();
    checkOutput("err13Gone", 384'(bus.cfg_err), 384'(0));
    applyStimulus(12, 3, 32'd1);
    checkOutput("err12",     384'(bus.cfg_err), 384'(1));
    doCommit("errCommit");
    expFreq = '0;
    expFreq[32*3 +: 32] = 32'hAAAA_0000;
    expFreq[32*5 +: 32] = 32'h0000_5555;
    checkOutput("errFreq",   384'(chan_freq),   384'(expFreq));
    checkOutput("errEnable", 384'(chan_enable), 384'(12'h008));

    // High bits of cfg_data are ignored per field.
    applyStimulus(0, 1, 32'hFFFF_1234);
    applyStimulus(0, 2, 32'hFFFF_FFC5);
    applyStimulus(0, 3, 32'h0000_0002);
    doCommit("maskCommit");
    checkOutput("maskCa0",    384'(chan_ca_sel[5:0]), 384'(6'h05));
    checkOutput("maskEnable", 384'(chan_enable),      384'(12'h008));
`ifdef SAT_CHAN_SCHED_GAIN_RAMP_EN
    repeat (20) tick();
`endif
    checkOutput("maskGain0",  384'(chan_gain[15:0]), 384'(16'h1234));
    applyStimulus(0, 3, 32'hFFFF_FFFF);
    doCommit("en0Commit");
    checkOutput("en0Enable",  384'(chan_enable), 384'(12'h009));

    // Reset while ARMED discards the pending commit and clears everything.
    bus.commit_req = 1'b1;
    tick();
    bus.commit_req = 1'b0;
    rst_n = 1'b0;
    tick();
    checkOutput("rstArmPending", 384'(bus.commit_pending), 384'(0));
    checkOutput("rstArmReady",   384'(bus.cfg_ready),      384'(0));
    checkOutput("rstArmFreq",    384'(chan_freq),          384'(0));
    checkOutput("rstArmEnable",  384'(chan_enable),        384'(0));
    rst_n = 1'b1;
    bus.epoch = 1'b1;
    tick();
    bus.epoch = 1'b0;
    tick();
    checkOutput("rstArmDone", 384'(bus.commit_done), 384'(0));
    doCommit("rstShadowCommit");
    checkOutput("rstShadowEnable", 384'(chan_enable), 384'(0));

    // Gain step/ramp on channel 1, then reset mid-way.
    applyStimulus(1, 1, 32'h0000_0300);
    doCommit("gainCommit");
`ifdef SAT_CHAN_SCHED_GAIN_RAMP_EN
    checkOutput("ramp0", 384'(chan_gain[16*1 +: 16]), 384'(16'h0100));
    tick();
    checkOutput("ramp1", 384'(chan_gain[16*1 +: 16]), 384'(16'h0200));
    tick();
    checkOutput("ramp2", 384'(chan_gain[16*1 +: 16]), 384'(16'h0300));
    tick();
    checkOutput("ramp3", 384'(chan_gain[16*1 +: 16]), 384'(16'h0300));
    applyStimulus(1, 1, 32'h0000_0000);
    doCommit("rampDownCommit");
    checkOutput("rampDown", 384'(chan_gain[16*1 +: 16]), 384'(16'h0200));
`else
    checkOutput("gainStep", 384'(chan_gain[16*1 +: 16]), 384'(16'h0300));
`endif
    rst_n = 1'b0;
    tick();
    checkOutput("gainRst", 384'(chan_gain), 384'(0));
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errCount);
    $finish;
  end
endmodule

// File: doc/sat_chan_sched.md
# sat_chan_sched

Configuration scheduler for the bank of `sat_chan` satellite channels in the GPS synthesizer.
- Host writes to each channel's Doppler frequency, gain, C/A select and enable go into a shadow bank.
- On request, the whole bank is committed atomically on the next C/A epoch strobe, so all channels change parameters on a code-period boundary.
- It sits between the host register interface and the `sat_chan` instances, and drives their `enable`, `freq`, `gain` and `ca_sel` inputs.

## Interface
Parameters:
- `NUM_CHAN`, 12: number of satellite channels driven. Range 1..64.
- `RAMP_STEP`, 256: gain slew per clock when ramping is compiled in. 16-bit unsigned, must be nonzero.

Ports (CW = max(1, clog2(NUM_CHAN))):
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cfg_valid`  in  1  config write request.
- `cfg_ready`  out  1  write accepted when high together with `cfg_valid`.
- `cfg_chan`  in  CW  target channel index.
- `cfg_field`  in  2  field select: 0 = freq, 1 = gain (low 16 bits), 2 = ca_sel (low 6 bits), 3 = enable (bit 0).
- `cfg_data`  in  32  write data.
- `cfg_err`  out  1  one-cycle pulse when an accepted write has `cfg_chan` ≥ NUM_CHAN.
- `commit_req`  in  1  one-cycle request to arm a commit.
- `epoch`  in  1  one-cycle C/A epoch strobe (1 ms).
- `commit_pending`  out  1  high while armed.
- `commit_done`  out  1  one-cycle pulse in the first cycle the new values are active.
- `chan_enable`  out  NUM_CHAN  per-channel enable.
- `chan_freq`  out  32*NUM_CHAN  channel i occupies bits [32i +: 32].
- `chan_gain`  out  16*NUM_CHAN  channel i occupies bits [16i +: 16].
- `chan_ca_sel`  out  6*NUM_CHAN  channel i occupies bits [6i +: 6].

## Operation
- FSM states: IDLE, ARMED, APPLY. Reset state is IDLE.
- IDLE:
  - `cfg_ready` = 1.
  - An accepted write updates the selected shadow field; unused high bits of `cfg_data` are ignored.
  - An out-of-range `cfg_chan` is accepted, dropped, and pulses `cfg_err`.
  - `commit_req` moves the FSM to ARMED.
  - `epoch` is ignored.
- ARMED:
  - `cfg_ready` = 0 and `commit_pending` = 1.
  - `commit_req` is ignored.
  - `epoch` moves the FSM to APPLY.
- APPLY (one cycle): all shadow fields are copied to the active registers, then the FSM returns to IDLE.
- `commit_req` and an accepted `cfg_valid` in the same IDLE cycle: the write lands in the shadow bank first and is included in the commit.
- `commit_req` and `epoch` in the same IDLE cycle: the FSM arms; the commit waits for the following epoch.
- The shadow bank is never modified by a commit. Uncommitted shadow state persists across commits.
- A freq/ca_sel/enable change on one channel never alters any other channel's outputs.
- Reset mid-operation, including while ARMED:
  - All shadow and active registers clear, any pending commit is discarded, and the FSM returns to IDLE.
  - Reset values: `chan_enable` = 0, `chan_freq` = 0, `chan_gain` = 0, `chan_ca_sel` = 0, `cfg_ready` = 0 during reset, `cfg_err` = 0, `commit_pending` = 0, `commit_done` = 0.

## Timing
- Shadow write: visible to a commit from the cycle after acceptance.
- `cfg_err`: pulses in the cycle after the accepted write.
- Arming: `commit_pending` rises the cycle after `commit_req` is sampled.
- Commit latency: `epoch` sampled in ARMED → APPLY next cycle → active outputs and `commit_done` change on the following cycle, i.e. 2 clocks after the epoch edge. `commit_pending` falls the same cycle as `commit_done` rises.
- After a commit, `cfg_ready` returns high the cycle after APPLY.
- All outputs are registered; there is no combinational path from inputs to outputs except `cfg_ready`, which depends on state only.

## Configuration
- `SAT_CHAN_SCHED_GAIN_RAMP_EN` defined:
  - Each `chan_gain` output slews toward its committed target by `RAMP_STEP` per clock, saturating exactly at the target with no overshoot, up or down.
  - Ramping starts in the `commit_done` cycle.
  - A new commit mid-ramp retargets from the current value.
  - Freq, ca_sel and enable still step atomically.
- Not defined: `chan_gain` steps to its target at commit like the other fields, and no ramp logic is synthesized.

## Test plan
- After reset: write ch 3 freq = 0x0123_4567, gain = 0x8000, ca_sel = 17, enable = 1; pulse `commit_req`; pulse `epoch` 10 cycles later → ch 3 outputs take these values and `commit_done` pulses exactly 2 clocks after the epoch; all other channels stay 0.
- `epoch` in IDLE without `commit_req` → no output change, no `commit_done`.
- `commit_req` and `epoch` in the same IDLE cycle → nothing applied; the next epoch applies.
- `cfg_valid` held high while ARMED → `cfg_ready` = 0, no shadow change; after the commit, the write is accepted.
- NUM_CHAN = 12, write to ch 13 → `cfg_err` pulses, and a commit shows no channel changed.
- Ramp build, RAMP_STEP = 256, gain 0 → 0x0300 → 0x0100, 0x0200, 0x0300 on successive cycles from `commit_done`. Assert `rst_n` low mid-ramp → gain 0 the next cycle.
